// File: rtl/glitch_pkg.sv
// Shared types and power-on defaults for the glitch burst generator.
package glitch_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StArmed,
    StDelay,
    StPulse,
    StGap,
    StDone
  } gb_state_e;

  // Defaults matching the old fixed DELAY_COUNT/PWIDTH_COUNT flow.
  localparam int unsigned DefDelay = 300;
  localparam int unsigned DefWidth = 300;
  localparam int unsigned DefGap   = 1;
  localparam int unsigned DefCount = 1;

endpackage

// File: rtl/trig_sync.sv
// Trigger synchroniser with selectable-polarity edge detector; edge_o is a registered
// one-cycle pulse.
module trig_sync #(
  parameter int unsigned SyncStages = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic trig_i,
  input  logic falling_i,
  output logic level_o,
  output logic edge_o
);

  logic [SyncStages-1:0] sync_q;
  logic                  prev_q;
  logic                  edge_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      edge_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SyncStages-2:0], trig_i};
      prev_q <= sync_q[SyncStages-1];
      edge_q <= falling_i ? (prev_q & ~sync_q[SyncStages-1])
                          : (~prev_q & sync_q[SyncStages-1]);
    end
  end

  assign level_o = sync_q[SyncStages-1];
  assign edge_o  = edge_q;

endmodule

// File: rtl/glitch_burst_gen.sv
// Triggered glitch burst generator: after a qualified trigger edge and a programmable
// delay, emits 1..N pulses of programmable width and gap on the glitch pin.
module glitch_burst_gen
  import glitch_pkg::*;
#(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned NUM_W       = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             CLK,
  input  logic             RESETB,
  input  logic             trigger,
  input  logic             arm,
  input  logic             abort,
  input  logic [CNT_W-1:0] cfg_delay,
  input  logic [CNT_W-1:0] cfg_width,
  input  logic [CNT_W-1:0] cfg_gap,
  input  logic [NUM_W-1:0] cfg_count,
  input  logic             cfg_falling,
  input  logic             cfg_invert,
  input  logic             cfg_auto,
  output logic             glitch,
  output logic             armed,
  output logic             delay_active,
  output logic             done,
  output logic [NUM_W-1:0] pulse_idx
);

  // Reset asserts asynchronously and releases synchronously to CLK.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge CLK or negedge RESETB) begin
    if (!RESETB) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_n = rst_sync_q[1];

  gb_state_e        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] delay_q;
  logic [CNT_W-1:0] width_m1_q;
  logic [CNT_W-1:0] gap_m1_q;
  logic [NUM_W-1:0] count_m1_q;
  logic             falling_q;
  logic             invert_q;
  logic             auto_q;
  logic             glitch_q;
  logic             armed_q;
  logic             delay_active_q;
  logic             done_q;
  logic [NUM_W-1:0] idx_q;

  logic trig_level;
  logic trig_edge;
  logic falling_sel;
  logic invert_sel;

  // Polarity and inversion follow the live inputs only while idle.
  assign falling_sel = (state_q == StIdle) ? cfg_falling : falling_q;
  assign invert_sel  = (state_q == StIdle) ? cfg_invert  : invert_q;

  trig_sync #(
    .SyncStages(SYNC_STAGES)
  ) u_trig_sync (
    .clk_i    (CLK),
    .rst_ni   (rst_n),
    .trig_i   (trigger),
    .falling_i(falling_sel),
    .level_o  (trig_level),
    .edge_o   (trig_edge)
  );

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      cnt_q          <= '0;
      delay_q        <= '0;
      width_m1_q     <= '0;
      gap_m1_q       <= '0;
      count_m1_q     <= '0;
      falling_q      <= 1'b0;
      invert_q       <= 1'b0;
      auto_q         <= 1'b0;
      glitch_q       <= 1'b0;
      armed_q        <= 1'b0;
      delay_active_q <= 1'b0;
      done_q         <= 1'b0;
      idx_q          <= '0;
    end else if (abort) begin
      state_q        <= StIdle;
      cnt_q          <= '0;
      glitch_q       <= 1'b0;
      armed_q        <= 1'b0;
      delay_active_q <= 1'b0;
      done_q         <= 1'b0;
      idx_q          <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (arm) begin
            // Zero width/gap/count behave as one; store them minus one for equality tests.
            delay_q    <= cfg_delay;
            width_m1_q <= (cfg_width == '0) ? '0 : cfg_width - CNT_W'(1);
            gap_m1_q   <= (cfg_gap == '0) ? '0 : cfg_gap - CNT_W'(1);
            count_m1_q <= (cfg_count == '0) ? '0 : cfg_count - NUM_W'(1);
            falling_q  <= cfg_falling;
            invert_q   <= cfg_invert;
            auto_q     <= cfg_auto;
            idx_q      <= '0;
            armed_q    <= 1'b1;
            state_q    <= StArmed;
          end
        end
        StArmed: begin
          if (trig_edge) begin
            armed_q <= 1'b0;
            cnt_q   <= '0;
            if (delay_q == '0) begin
              glitch_q <= 1'b1;
              state_q  <= StPulse;
            end else begin
              delay_active_q <= 1'b1;
              state_q        <= StDelay;
            end
          end
        end
        StDelay: begin
          if (cnt_q == delay_q - CNT_W'(1)) begin
            cnt_q          <= '0;
            delay_active_q <= 1'b0;
            glitch_q       <= 1'b1;
            state_q        <= StPulse;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        StPulse: begin
          if (cnt_q == width_m1_q) begin
            cnt_q    <= '0;
            glitch_q <= 1'b0;
            idx_q    <= idx_q + NUM_W'(1);
            if (idx_q == count_m1_q) begin
              done_q  <= 1'b1;
              state_q <= StDone;
            end else begin
              state_q <= StGap;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        StGap: begin
          if (cnt_q == gap_m1_q) begin
            cnt_q    <= '0;
            glitch_q <= 1'b1;
            state_q  <= StPulse;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        StDone: begin
          // Inactive level equals the selected edge polarity bit.
          if (trig_level == falling_q) begin
            done_q <= 1'b0;
            idx_q  <= '0;
            if (auto_q) begin
              armed_q <= 1'b1;
              state_q <= StArmed;
            end else begin
              state_q <= StIdle;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Inversion is constant outside idle, so the XOR cannot glitch mid-burst.
  assign glitch       = glitch_q ^ invert_sel;
  assign armed        = armed_q;
  assign delay_active = delay_active_q;
  assign done         = done_q;
  assign pulse_idx    = idx_q;

endmodule
